// File: rtl/comparator_serial_sequencer.sv
// Bit-serial magnitude comparison controller: walks an operand pair MSB first
// through one shared external 1-bit comparator and stops at the first differing bit.
module comparator_serial_sequencer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clock_In,
  input  logic                  Reset_n_In,
  input  logic                  Start_In,
  input  logic                  Abort_In,
  input  logic [DATA_WIDTH-1:0] Data_A_In,
  input  logic [DATA_WIDTH-1:0] Data_B_In,
  output logic                  Comp_Enable_Out,
  output logic                  Comp_A_Out,
  output logic                  Comp_B_Out,
  input  logic                  Comp_gt_In,
  input  logic                  Comp_eq_In,
  input  logic                  Comp_lt_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic                  A_gt_B_Out,
  output logic                  A_eq_B_Out,
  output logic                  A_lt_B_Out,
  output logic                  Error_Out
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   a_reg, b_reg;
  logic [IDX_W-1:0]        idx;
  logic                    load, dec, res_en;
  logic [3:0]              res_nxt;

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) state <= IDLE;
    else             state <= state_nxt;
  end

  // Abort wins over everything; any comparator answer that is not one-hot
  // (X/Z included, since case matching is exact) is reported as an error.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    dec       = 1'b0;
    res_en    = 1'b0;
    res_nxt   = 4'b0000;
    case (state)
      IDLE: begin
        if (Start_In) begin
          load      = 1'b1;
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        if (Abort_In) begin
          state_nxt = IDLE;
        end else begin
          case ({Comp_gt_In, Comp_eq_In, Comp_lt_In})
            3'b100: begin
              res_en    = 1'b1;
              res_nxt   = 4'b1000;
              state_nxt = DONE;
            end
            3'b001: begin
              res_en    = 1'b1;
              res_nxt   = 4'b0010;
              state_nxt = DONE;
            end
            3'b010: begin
              if (idx == '0) begin
                res_en    = 1'b1;
                res_nxt   = 4'b0100;
                state_nxt = DONE;
              end else begin
                dec = 1'b1;
              end
            end
            default: begin
              res_en    = 1'b1;
              res_nxt   = 4'b0001;
              state_nxt = DONE;
            end
          endcase
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      a_reg      <= '0;
      b_reg      <= '0;
      idx        <= IDX_MSB;
      A_gt_B_Out <= 1'b0;
      A_eq_B_Out <= 1'b0;
      A_lt_B_Out <= 1'b0;
      Error_Out  <= 1'b0;
    end else begin
      if (load) begin
        a_reg      <= Data_A_In;
        b_reg      <= Data_B_In;
        idx        <= IDX_MSB;
        A_gt_B_Out <= 1'b0;
        A_eq_B_Out <= 1'b0;
        A_lt_B_Out <= 1'b0;
        Error_Out  <= 1'b0;
      end
      if (dec) idx <= idx - 1'b1;
      if (res_en) {A_gt_B_Out, A_eq_B_Out, A_lt_B_Out, Error_Out} <= res_nxt;
    end
  end

  assign Comp_Enable_Out = (state == COMPARE);
  assign Comp_A_Out      = (state == COMPARE) ? a_reg[idx] : 1'b0;
  assign Comp_B_Out      = (state == COMPARE) ? b_reg[idx] : 1'b0;
  assign Busy_Out        = (state != IDLE);
  assign Done_Out        = (state == DONE);

endmodule

// File: tb/tb_comparator_serial_sequencer.sv
// Directed bench for comparator_serial_sequencer with a behavioural 1-bit
// comparator on the Comp_* ports and an injectable non-one-hot fault.
module tb_comparator_serial_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort_req;
  logic [7:0] data_a, data_b;
  logic       comp_en, comp_a, comp_b;
  logic       comp_gt, comp_eq, comp_lt;
  logic       busy, done, gt, eq, lt, err;
  logic       fault_inj;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  // The real comparator floats its outputs when disabled; the sequencer never
  // samples them there, so this model simply drives 0.
  assign comp_gt = !comp_en ? 1'b0 : (fault_inj ? 1'b1 : (comp_a & ~comp_b));
  assign comp_eq = !comp_en ? 1'b0 : (fault_inj ? 1'b1 : ~(comp_a ^ comp_b));
  assign comp_lt = !comp_en ? 1'b0 : (fault_inj ? 1'b0 : (~comp_a & comp_b));

  comparator_serial_sequencer #(.DATA_WIDTH(8)) dut (
    .Clock_In        (clk),
    .Reset_n_In      (rst_n),
    .Start_In        (start),
    .Abort_In        (abort_req),
    .Data_A_In       (data_a),
    .Data_B_In       (data_b),
    .Comp_Enable_Out (comp_en),
    .Comp_A_Out      (comp_a),
    .Comp_B_Out      (comp_b),
    .Comp_gt_In      (comp_gt),
    .Comp_eq_In      (comp_eq),
    .Comp_lt_In      (comp_lt),
    .Busy_Out        (busy),
    .Done_Out        (done),
    .A_gt_B_Out      (gt),
    .A_eq_B_Out      (eq),
    .A_lt_B_Out      (lt),
    .Error_Out       (err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns in the middle of cycle 1 (first cycle after the accepting edge).
  task automatic start_only(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    data_a = a;
    data_b = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Returns in the middle of the Done cycle (or after a 20-cycle bound).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int done_cyc, output int busy_cyc);
    done_cyc = 0;
    busy_cyc = 0;
    start_only(a, b);
    for (int c = 1; c <= 20; c++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic int exp_done_cycle(input logic [7:0] a, input logic [7:0] b);
    for (int i = 7; i >= 0; i--)
      if (a[i] != b[i]) return 8 - i + 1;
    return 9;
  endfunction

  initial begin
    int dc, bc;
    logic [7:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; abort_req = 1'b0;
    data_a = '0; data_b = '0; fault_inj = 1'b0;

    // 1: reset
    repeat (2) @(negedge clk);
    check_val("rst_outs_low", {comp_en, comp_a, comp_b, busy, done, gt, eq, lt, err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_outs_after", {comp_en, comp_a, comp_b, busy, done, gt, eq, lt, err}, 0);

    // 2: MSB differs
    run_op(8'h80, 8'h7F, dc, bc);
    check_val("gt_done_cyc", dc, 2);
    check_val("gt_busy_cyc", bc, 2);
    check_val("gt_result", {gt, eq, lt, err}, 4'b1000);
    @(negedge clk);
    check_val("gt_done_pulse", {done, busy}, 2'b00);
    check_val("gt_hold", {gt, eq, lt, err}, 4'b1000);

    // 3: equal, then LSB differs
    run_op(8'h5A, 8'h5A, dc, bc);
    check_val("eq_done_cyc", dc, 9);
    check_val("eq_busy_cyc", bc, 9);
    check_val("eq_result", {gt, eq, lt, err}, 4'b0100);
    run_op(8'h12, 8'h13, dc, bc);
    check_val("lt_done_cyc", dc, 9);
    check_val("lt_result", {gt, eq, lt, err}, 4'b0010);

    // 4a: second start during COMPARE is ignored
    start_only(8'h00, 8'hFF);
    check_val("busy_c1_cmp_en", {busy, comp_en, comp_a, comp_b}, 4'b1101);
    start = 1'b1; data_a = 8'hFF; data_b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    check_val("ign_done_c2", done, 1'b1);
    check_val("ign_result", {gt, eq, lt, err}, 4'b0010);
    @(negedge clk);
    check_val("ign_idle_c3", {busy, done}, 2'b00);

    // 4b: abort in cycle 3
    start_only(8'h5A, 8'h5A);
    @(negedge clk);
    check_val("abort_c2", {busy, done}, 2'b10);
    @(negedge clk);
    abort_req = 1'b1;
    check_val("abort_c3_busy", busy, 1'b1);
    @(negedge clk);
    abort_req = 1'b0;
    check_val("abort_c4_idle", {busy, done, comp_en}, 3'b000);
    check_val("abort_cleared", {gt, eq, lt, err}, 4'b0000);

    // 5: async reset in cycle 4
    start_only(8'h01, 8'h01);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_outs", {comp_en, comp_a, comp_b, busy, done, gt, eq, lt, err}, 0);
    @(negedge clk);
    check_val("rst_mid_no_done", done, 1'b0);
    rst_n = 1'b1;
    run_op(8'h01, 8'h01, dc, bc);
    check_val("post_rst_done_cyc", dc, 9);
    check_val("post_rst_result", {gt, eq, lt, err}, 4'b0100);

    // 6: non-one-hot comparator answer
    fault_inj = 1'b1;
    run_op(8'h33, 8'h33, dc, bc);
    check_val("err_done_cyc", dc, 2);
    check_val("err_result", {gt, eq, lt, err}, 4'b0001);
    @(negedge clk);
    check_val("err_pulse_hold", {done, busy, err}, 3'b001);
    fault_inj = 1'b0;

    // 6: random operand pairs
    for (int n = 0; n < 10; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (n == 3) ? ra : 8'($urandom_range(0, 255));
      run_op(ra, rb, dc, bc);
      check_val($sformatf("rnd%0d_done_cyc", n), dc, exp_done_cycle(ra, rb));
      check_val($sformatf("rnd%0d_result", n), {gt, eq, lt, err},
                {ra > rb, ra == rb, ra < rb, 1'b0});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
